fifo_round_robin_writer: RTL and testbench

//   Shares the write port of one fifo_single_clock between NUM_REQUESTERS sources.

---
 rtl/fifo_round_robin_writer.sv | 154 +++++++++++++++
 tb/tb_fifo_round_robin_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_round_robin_writer.sv
// fifo_round_robin_writer
//   Round-robin arbiter that shares the write port of a single-clock FIFO
//   between NUM_REQUESTERS valid/ready sources. The winning word is written
//   to the FIFO through registered write_enable/data_in one cycle after the
//   accept. Grants are throttled from full/almost_full so that a write is
//   never presented to a full FIFO, counting the write still in flight.
//   Optional packet locking is enabled by defining FIFO_ARB_PACKET_EN: once a
//   source wins with req_last=0 it keeps the port until it sends req_last=1.
module fifo_round_robin_writer #(
  parameter int NUM_REQUESTERS  = 4,
  parameter int LOG2_OF_NUM_REQ = 2,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]            req_last,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  input  logic                                 fifo_full,
  input  logic                                 fifo_almost_full,
  output logic                                 fifo_write_enable,
  output logic [DATA_WIDTH-1:0]                fifo_data_in,
  output logic [LOG2_OF_NUM_REQ-1:0]           grant_index,
  output logic [31:0]                          stall_count
);

  // One extra bit so pointer + offset can exceed NUM_REQUESTERS-1 before wrap.
  localparam int SUM_W = LOG2_OF_NUM_REQ + 1;

  logic [LOG2_OF_NUM_REQ-1:0] ptr_q;
  logic [LOG2_OF_NUM_REQ-1:0] ptr_d;
  logic                       we_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [LOG2_OF_NUM_REQ-1:0] grant_q;
  logic [31:0]                stall_q;
  logic [31:0]                stall_d;

  logic [DATA_WIDTH-1:0]      req_word [NUM_REQUESTERS];
  logic                       scan_found;
  logic [LOG2_OF_NUM_REQ-1:0] scan_win;
  logic [SUM_W-1:0]           scan_sum;
  logic [LOG2_OF_NUM_REQ-1:0] scan_idx;
  logic                       found;
  logic [LOG2_OF_NUM_REQ-1:0] win_idx;
  logic                       accept_ok;
  logic                       accept;

  // Unpack the flat data bus into one word per source.
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_word
    assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Circular scan starting at the priority pointer; first valid source wins.
  always_comb begin
    scan_found = 1'b0;
    scan_win   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      scan_sum = {1'b0, ptr_q} + SUM_W'(k);
      if (scan_sum >= SUM_W'(NUM_REQUESTERS)) begin
        scan_sum = scan_sum - SUM_W'(NUM_REQUESTERS);
      end
      scan_idx = scan_sum[LOG2_OF_NUM_REQ-1:0];
      if (!scan_found && req_valid[scan_idx]) begin
        scan_found = 1'b1;
        scan_win   = scan_idx;
      end
    end
  end

`ifdef FIFO_ARB_PACKET_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state_q;
  logic [LOG2_OF_NUM_REQ-1:0] locked_q;

  // While a packet is open only its owner may be granted.
  assign found   = (state_q == LOCKED) ? req_valid[locked_q] : scan_found;
  assign win_idx = (state_q == LOCKED) ? locked_q : scan_win;
`else
  // Word-granular arbitration: packet boundaries are irrelevant.
  logic unused_last;
  assign unused_last = ^req_last;
  assign found       = scan_found;
  assign win_idx     = scan_win;
`endif

  // A write already in flight into an almost-full FIFO fills it, so hold off.
  assign accept_ok = ~fifo_full & ~(fifo_almost_full & we_q);
  assign accept    = ~reset & found & accept_ok;

  // Ready goes only to the winner, and only when the FIFO can take the word.
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_ready
    assign req_ready[gi] = accept & (win_idx == LOG2_OF_NUM_REQ'(gi));
  end

  // Next priority pointer and saturating stall counter.
  always_comb begin
    ptr_d = (win_idx == LOG2_OF_NUM_REQ'(NUM_REQUESTERS - 1)) ? '0 : win_idx + 1'b1;
    stall_d = stall_q;
    if ((|req_valid) && !accept && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Registered FIFO write port, pointer rotation, stall counting and packet FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= '0;
      we_q     <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      stall_q  <= '0;
`ifdef FIFO_ARB_PACKET_EN
      state_q  <= IDLE;
      locked_q <= '0;
`endif
    end else begin
      we_q    <= accept;
      stall_q <= stall_d;
      if (accept) begin
        data_q  <= req_word[win_idx];
        grant_q <= win_idx;
        ptr_q   <= ptr_d;
      end
`ifdef FIFO_ARB_PACKET_EN
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (!req_last[win_idx]) begin
              state_q  <= LOCKED;
              locked_q <= win_idx;
            end
          end
          LOCKED: begin
            if (req_last[win_idx]) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
`endif
    end
  end

  assign fifo_write_enable = we_q;
  assign fifo_data_in      = data_q;
  assign grant_index       = grant_q;
  assign stall_count       = stall_q;

endmodule

// File: tb/tb_fifo_round_robin_writer.sv
// tb_fifo_round_robin_writer
//   Scoreboard bench for fifo_round_robin_writer with a behavioural arbiter
//   model, a depth-16 FIFO occupancy model and directed plus random phases.
//   Build with FIFO_ARB_PACKET_EN defined to exercise packet locking.
module tb_fifo_round_robin_writer;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_write_enable;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant_index;
  logic [31:0]   stall_count;

  fifo_round_robin_writer #(
    .NUM_REQUESTERS (N),
    .LOG2_OF_NUM_REQ(2),
    .DATA_WIDTH     (DW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_write_enable(fifo_write_enable),
    .fifo_data_in     (fifo_data_in),
    .grant_index      (grant_index),
    .stall_count      (stall_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // stimulus state
  logic [DW-1:0] src_data [N];
  int  gen_mode;     // 0 hold after accept, 1 random, 2 drop after accept, 3 scripted packet
  int  s0_words;
  bit  force_full;
  bit  rd_random;
  bit  rd_one;
  int  fifo_cnt;
  logic [N-1:0] ready_seen;

  // reference model
  int          ptr_m;
  bit          we_m;
  logic [31:0] stall_m;
  bit          locked_m;
  int          lock_src_m;

  // scoreboard and logs
  logic [DW-1:0] exp_data_q [$];
  int            exp_grant_q[$];
  int            grant_log  [$];
  logic [DW-1:0] data_log   [$];
  int            write_count = 0;
  logic [DW-1:0] mon_ed;
  int            mon_eg;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every FIFO write is compared with the oldest expected word.
  always @(negedge clock) begin
    if (fifo_write_enable === 1'b1) begin
      write_count++;
      grant_log.push_back(int'(grant_index));
      data_log.push_back(fifo_data_in);
      tests++;
      if (exp_data_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: actual data %0h grant %0d, required no write", fifo_data_in, grant_index);
      end else begin
        mon_ed = exp_data_q.pop_front();
        mon_eg = exp_grant_q.pop_front();
        if (fifo_data_in !== mon_ed || int'(grant_index) != mon_eg) begin
          fails++;
          $display("FAIL write_word: actual data %0h grant %0d, required data %0h grant %0d",
                   fifo_data_in, grant_index, mon_ed, mon_eg);
        end
      end
    end
  end

  // One clock cycle: drive, predict, check, advance model and sources.
  task automatic do_cycle();
    int win;
    int cand;
    bit ok;
    bit acc;
    bit stalled;
    bit we_seen;
    bit rd;
    bit last_w;
    logic [N-1:0] exp_ready;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = src_data[i];
    fifo_full        = force_full || (fifo_cnt >= DEPTH);
    fifo_almost_full = (fifo_cnt >= DEPTH - 1);
    rd = (fifo_cnt > 0) && (rd_one || (rd_random && $urandom_range(0, 2) == 0));
    rd_one = 1'b0;
    #1;
    we_seen = fifo_write_enable;
    check_eq("write_enable", fifo_write_enable, we_m);
    if (we_seen) check_eq("no_write_into_full", fifo_cnt >= DEPTH, 0);
    ok  = !fifo_full && !(fifo_almost_full && we_m);
    win = -1;
    if (locked_m) begin
      if (req_valid[lock_src_m]) win = lock_src_m;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = (ptr_m + k) % N;
        if (win < 0 && req_valid[cand]) win = cand;
      end
    end
    exp_ready = '0;
    if (!reset && win >= 0 && ok) exp_ready[win] = 1'b1;
    ready_seen = req_ready;
    check_eq("req_ready", req_ready, exp_ready);
    acc     = (exp_ready != '0);
    last_w  = acc ? req_last[win] : 1'b0;
    stalled = !reset && (req_valid != '0) && !acc;
    if (acc) begin
      exp_data_q.push_back(src_data[win]);
      exp_grant_q.push_back(win);
    end
    @(posedge clock);
    #1;
    if (reset) fifo_cnt = 0;
    else fifo_cnt = fifo_cnt + (we_seen ? 1 : 0) - (rd ? 1 : 0);
    if (reset) begin
      ptr_m = 0; we_m = 1'b0; stall_m = '0; locked_m = 1'b0; lock_src_m = 0;
    end else begin
      we_m = acc;
      if (acc) ptr_m = (win + 1) % N;
`ifdef FIFO_ARB_PACKET_EN
      if (acc) begin
        if (!locked_m) begin
          if (!last_w) begin
            locked_m   = 1'b1;
            lock_src_m = win;
          end
        end else if (last_w) begin
          locked_m = 1'b0;
        end
      end
`endif
      if (stalled && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
    end
    check_eq("stall_count", stall_count, stall_m);
    if (acc) begin
      case (gen_mode)
        1: begin
          req_valid[win] = 1'($urandom_range(0, 1));
          src_data[win]  = 8'($urandom);
          req_last[win]  = ($urandom_range(0, 2) == 0);
        end
        2: req_valid[win] = 1'b0;
        3: if (win == 0) begin
          s0_words++;
          src_data[0] = 8'hA0 + 8'(s0_words);
          if (s0_words >= 3) req_valid[0] = 1'b0;
          else req_last[0] = (s0_words == 2);
        end
        default: ;
      endcase
    end
    if (gen_mode == 1) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          src_data[i]  = 8'($urandom);
          req_last[i]  = ($urandom_range(0, 2) == 0);
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) do_cycle();
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    data_log.delete();
  endtask

  int base;
  int t2_exp [6] = '{0, 1, 2, 3, 0, 1};
`ifdef FIFO_ARB_PACKET_EN
  int t6_exp [4] = '{0, 0, 0, 1};
`else
  int t6_exp [5] = '{0, 1, 0, 1, 0};
`endif

  initial begin
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    for (int i = 0; i < N; i++) src_data[i] = '0;
    gen_mode = 2; s0_words = 0; force_full = 0; rd_random = 0; rd_one = 0; fifo_cnt = 0;
    ptr_m = 0; we_m = 0; stall_m = '0; locked_m = 0; lock_src_m = 0;
    @(posedge clock);
    #1;

    // Reset held, then a single request from source 2
    do_reset(4);
    check_eq("t1_reset_we", fifo_write_enable, 0);
    check_eq("t1_reset_data", fifo_data_in, 0);
    check_eq("t1_reset_grant", grant_index, 0);
    check_eq("t1_reset_stall", stall_count, 0);
    check_eq("t1_reset_ready", req_ready, 0);
    req_last = '1;
    src_data[2] = 8'h5A;
    req_valid = 4'b0100;
    clear_logs();
    do_cycle();
    check_eq("t1_ready_src2", ready_seen, 4'b0100);
    do_cycle();
    check_eq("t1_write_count", grant_log.size(), 1);
    if (grant_log.size() >= 1) begin
      check_eq("t1_grant", grant_log[0], 2);
      check_eq("t1_data", data_log[0], 8'h5A);
    end

    // All four sources streaming
    req_valid = '0;
    do_reset(2);
    gen_mode = 0;
    for (int i = 0; i < N; i++) src_data[i] = 8'(i * 8'h11);
    req_valid = 4'hF;
    clear_logs();
    repeat (7) do_cycle();
    check_eq("t2_write_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check_eq("t2_grant_order", grant_log[i], t2_exp[i]);
    check_eq("t2_stall", stall_count, 0);

    // Source 0 fills a depth-16 FIFO with no reads, then one read
    req_valid = '0;
    do_reset(2);
    gen_mode = 0;
    src_data[0] = 8'hC3;
    req_valid = 4'b0001;
    base = write_count;
    repeat (30) do_cycle();
    check_eq("t3_writes_landed", write_count - base, 16);
    check_eq("t3_fifo_level", fifo_cnt, 16);
    check_eq("t3_stall_nonzero", stall_count != 0, 1);
    rd_one = 1'b1;
    base = write_count;
    repeat (10) do_cycle();
    check_eq("t3_one_more_write", write_count - base, 1);

    // FIFO full for 10 cycles with sources 1 and 3 waiting
    req_valid = '0;
    do_reset(2);
    gen_mode = 2;
    force_full = 1'b1;
    src_data[1] = 8'h31; src_data[3] = 8'h33;
    req_valid = 4'b1010;
    clear_logs();
    repeat (10) do_cycle();
    check_eq("t4_stall_10", stall_count, 10);
    check_eq("t4_no_writes", grant_log.size(), 0);
    force_full = 1'b0;
    repeat (4) do_cycle();
    check_eq("t4_write_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_eq("t4_first_src1", grant_log[0], 1);
      check_eq("t4_then_src3", grant_log[1], 3);
    end

    // Reset on the cycle after an accept
    req_valid = '0;
    do_reset(2);
    gen_mode = 2;
    src_data[2] = 8'h77;
    req_valid = 4'b0100;
    do_cycle();
    do_reset(2);
    check_eq("t5_we_dropped", fifo_write_enable, 0);
    check_eq("t5_data_cleared", fifo_data_in, 0);
    check_eq("t5_grant_cleared", grant_index, 0);
    gen_mode = 0;
    for (int i = 0; i < N; i++) src_data[i] = 8'(8'h50 + i);
    req_valid = 4'hF;
    clear_logs();
    repeat (3) do_cycle();
    if (grant_log.size() >= 1) check_eq("t5_src0_first", grant_log[0], 0);
    else check_eq("t5_write_seen", grant_log.size(), 1);

    // Three-word packet from source 0 against a steady source 1
    req_valid = '0;
    do_reset(2);
    gen_mode = 3;
    s0_words = 0;
    src_data[0] = 8'hA0; src_data[1] = 8'hB1;
    req_last = 4'b0010;
    req_valid = 4'b0011;
    clear_logs();
    repeat (7) do_cycle();
    for (int i = 0; i < $size(t6_exp); i++) begin
      if (i < grant_log.size()) check_eq("t6_grant_order", grant_log[i], t6_exp[i]);
      else check_eq("t6_write_missing", grant_log.size(), $size(t6_exp));
    end

    // Randomised traffic with random FIFO reads
    req_valid = '0;
    do_reset(2);
    gen_mode = 1;
    rd_random = 1'b1;
    repeat (3000) do_cycle();
    gen_mode = 2;
    repeat (200) do_cycle();
    req_valid = '0;
    repeat (4) do_cycle();
    check_eq("final_scoreboard_empty", exp_data_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
